// File: rtl/pc_branch_unit.sv
// rtl/pc_branch_unit.sv - fetch PC register with branch/jump redirect, flush window, stall hold and halt.
// Optional PC_ALIGN_CHECK_EN: odd redirect targets halt the core and set sticky misalign_err.
module pc_branch_unit #(
  parameter int                  PC_WIDTH     = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC     = '0,
  parameter int                  INSTR_BYTES  = 2,
  parameter int                  FLUSH_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                stall,
  input  logic                branch_taken,
  input  logic                jump,
  input  logic [PC_WIDTH-1:0] offset,
  input  logic [PC_WIDTH-1:0] branch_pc,
  input  logic                halt,
  output logic [PC_WIDTH-1:0] pc,
  output logic [PC_WIDTH-1:0] pc_plus,
  output logic                flush,
  output logic                redirect,
  output logic                halted,
  output logic                misalign_err
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    FLUSH  = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam logic [PC_WIDTH-1:0] INC      = PC_WIDTH'(INSTR_BYTES);
  localparam logic [2:0]          CNT_INIT = 3'(FLUSH_CYCLES - 1);

  state_t              state;
  logic [2:0]          cnt;
  logic [PC_WIDTH-1:0] sum;
  logic [PC_WIDTH-1:0] target;
  logic                take;
  logic                odd_target;

  assign sum     = branch_pc + offset;
  assign pc_plus = pc + INC;
  assign take    = branch_taken | jump;

`ifdef PC_ALIGN_CHECK_EN
  assign target     = sum;
  assign odd_target = target[0];
`else
  assign target     = sum & ~PC_WIDTH'(1);
  assign odd_target = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      pc       <= RESET_PC;
      cnt      <= 3'd0;
      flush    <= 1'b0;
      redirect <= 1'b0;
      halted   <= 1'b0;
    end else begin
      redirect <= 1'b0;
      case (state)
        RUN: begin
          if (stall) begin
            pc <= pc;
          end else if (halt) begin
            state  <= HALTED;
            halted <= 1'b1;
          end else if (take && odd_target) begin
            // Misaligned redirect: keep the old pc and stop rather than fetch garbage.
            state  <= HALTED;
            halted <= 1'b1;
          end else if (take) begin
            pc       <= target;
            redirect <= 1'b1;
            flush    <= 1'b1;
            cnt      <= CNT_INIT;
            state    <= FLUSH;
          end else begin
            pc <= pc_plus;
          end
        end
        FLUSH: begin
          // Control inputs here belong to squashed instructions and are ignored.
          if (!stall) begin
            pc <= pc_plus;
            if (cnt == 3'd0) begin
              state <= RUN;
              flush <= 1'b0;
            end else begin
              cnt <= cnt - 3'd1;
            end
          end
        end
        default: begin
          halted <= 1'b1;
        end
      endcase
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_err <= 1'b0;
    end else if (state == RUN && !stall && !halt && take && odd_target) begin
      misalign_err <= 1'b1;
    end
  end
`else
  assign misalign_err = 1'b0;
`endif

endmodule

// File: tb/tb_pc_branch_unit.sv
// tb/tb_pc_branch_unit.sv - directed and random checks of pc_branch_unit (FLUSH_CYCLES 1 and 2) against a reference model.
module tb_pc_branch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, stall, branch_taken, jump, halt;
  logic [15:0] offset, branch_pc;
  logic [15:0] pc      [2];
  logic [15:0] pc_plus [2];
  logic        flush [2], redirect [2], halted [2], misalign_err [2];

  int checks = 0;
  int errors = 0;

  // Reference model: pc value, number of flush cycles still owed, halt/misalign flags.
  logic [15:0] m_pc   [2];
  int          m_left [2];
  bit          m_halt [2], m_mis [2], m_red [2];
  int          fc     [2] = '{1, 2};

`ifdef PC_ALIGN_CHECK_EN
  bit align_chk = 1'b1;
`else
  bit align_chk = 1'b0;
`endif

  pc_branch_unit #(.FLUSH_CYCLES(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .stall(stall), .branch_taken(branch_taken), .jump(jump),
    .offset(offset), .branch_pc(branch_pc), .halt(halt), .pc(pc[0]), .pc_plus(pc_plus[0]),
    .flush(flush[0]), .redirect(redirect[0]), .halted(halted[0]), .misalign_err(misalign_err[0])
  );

  pc_branch_unit #(.FLUSH_CYCLES(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .stall(stall), .branch_taken(branch_taken), .jump(jump),
    .offset(offset), .branch_pc(branch_pc), .halt(halt), .pc(pc[1]), .pc_plus(pc_plus[1]),
    .flush(flush[1]), .redirect(redirect[1]), .halted(halted[1]), .misalign_err(misalign_err[1])
  );

  task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_pc[d] = 16'h0000; m_left[d] = 0; m_halt[d] = 0; m_mis[d] = 0; m_red[d] = 0;
    end
  endtask

  task automatic model_step();
    int          t;
    logic [15:0] tgt;
    for (int d = 0; d < 2; d++) begin
      m_red[d] = 0;
      if (m_halt[d]) continue;
      if (m_left[d] > 0) begin
        if (!stall) begin
          m_pc[d] = 16'((int'(m_pc[d]) + 2) % 65536);
          m_left[d]--;
        end
      end else if (!stall) begin
        if (halt) begin
          m_halt[d] = 1;
        end else if (branch_taken || jump) begin
          t   = (int'(branch_pc) + int'(offset)) % 65536;
          tgt = 16'(t);
          if (align_chk && (t % 2 == 1)) begin
            m_halt[d] = 1;
            m_mis[d]  = 1;
          end else begin
            m_pc[d]   = align_chk ? tgt : 16'(t - (t % 2));
            m_red[d]  = 1;
            m_left[d] = fc[d];
          end
        end else begin
          m_pc[d] = 16'((int'(m_pc[d]) + 2) % 65536);
        end
      end
    end
  endtask

  task automatic check_all(string where);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s d%0d pc", where, d), pc[d], m_pc[d]);
      chk($sformatf("%s d%0d pc_plus", where, d), pc_plus[d], 16'((int'(m_pc[d]) + 2) % 65536));
      chk($sformatf("%s d%0d flush", where, d), 16'(flush[d]), 16'(m_left[d] > 0));
      chk($sformatf("%s d%0d redirect", where, d), 16'(redirect[d]), 16'(m_red[d]));
      chk($sformatf("%s d%0d halted", where, d), 16'(halted[d]), 16'(m_halt[d]));
      chk($sformatf("%s d%0d misalign", where, d), 16'(misalign_err[d]), 16'(m_mis[d]));
    end
  endtask

  task automatic step(string where, bit s, bit b, bit j, bit h, logic [15:0] bpc, logic [15:0] off);
    stall = s; branch_taken = b; jump = j; halt = h; branch_pc = bpc; offset = off;
    @(posedge clk);
    model_step();
    #1;
    check_all(where);
  endtask

  task automatic do_reset(string where);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all(where);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; stall = 0; branch_taken = 0; jump = 0; halt = 0;
    branch_pc = '0; offset = '0;
    model_reset();
    do_reset("reset");

    repeat (4) step("seq", 0, 0, 0, 0, 16'h0000, 16'h0000);
    repeat (4) step("to_10", 0, 0, 0, 0, 16'h0000, 16'h0000);
    step("br_back", 0, 1, 0, 0, 16'h0012, 16'hFFF8);
    repeat (3) step("after_br", 0, 0, 0, 0, 16'h0000, 16'h0000);

    step("jump_wrap", 0, 0, 1, 0, 16'hFFFE, 16'h0004);
    repeat (3) step("after_jw", 0, 0, 0, 0, 16'h0000, 16'h0000);
    step("jump_top", 0, 0, 1, 0, 16'hFFF0, 16'h000A);
    repeat (4) step("seq_wrap", 0, 0, 0, 0, 16'h0000, 16'h0000);

    repeat (3) step("br_stall", 1, 1, 0, 0, 16'h0100, 16'h0020);
    step("br_go", 0, 1, 0, 0, 16'h0100, 16'h0020);
    repeat (2) step("fl_stall", 1, 1, 0, 0, 16'h0300, 16'h0000);
    repeat (3) step("fl_go", 0, 0, 0, 0, 16'h0000, 16'h0000);

    step("both", 0, 1, 1, 0, 16'h0040, 16'h0002);
    repeat (3) step("after_both", 0, 0, 0, 0, 16'h0000, 16'h0000);

    step("pre_rst", 0, 0, 1, 0, 16'h0200, 16'h0000);
    do_reset("rst_mid_flush");

    step("to_1c", 0, 0, 1, 0, 16'h001C, 16'h0000);
    repeat (2) step("to_20", 0, 0, 0, 0, 16'h0000, 16'h0000);
    step("halt", 0, 0, 0, 1, 16'h0000, 16'h0000);
    repeat (10) step("halted", 0, 0, 1, 0, 16'h0000, 16'h0004);
    do_reset("rst_halted");

    step("to_0c", 0, 0, 1, 0, 16'h000C, 16'h0000);
    repeat (2) step("to_10b", 0, 0, 0, 0, 16'h0000, 16'h0000);
    step("misalign", 0, 0, 1, 0, 16'h0011, 16'h0000);
    repeat (2) step("after_mis", 0, 0, 0, 0, 16'h0000, 16'h0000);
    do_reset("rst_mis");

    for (int i = 0; i < 400; i++) begin
      step("rand", ($urandom % 4) == 0, ($urandom % 5) == 0, ($urandom % 8) == 0,
           ($urandom % 60) == 0, 16'($urandom), 16'($urandom));
      if ((i % 97) == 96 || (m_halt[0] && m_halt[1] && ($urandom % 4) == 0))
        do_reset("rand_rst");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_branch_unit.md
Name: pc_branch_unit

Overview:
- Program-counter and branch-redirect stage. It sits directly downstream of the sign-extend/shift stage and consumes its 16-bit shifted offset.
- Holds the architectural fetch PC and computes the branch/jump target as branch_pc + offset.
- Redirects fetch on a taken branch or a jump, then asserts a flush to the IF/ID stage for a fixed number of cycles.
- Also provides stall hold and a terminal halt state.

Parameters:
- PC_WIDTH, 16, width of PC, offset and target.
- RESET_PC, 16'h0000, PC value loaded on reset.
- INSTR_BYTES, 2, sequential PC increment.
- FLUSH_CYCLES, 1, number of cycles flush stays high after a redirect (range 1..7).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  hazard stall; hold PC.
- branch_taken  in  1  conditional branch resolved taken (ID stage).
- jump  in  1  unconditional jump (ID stage).
- offset  in  PC_WIDTH  sign-extended, shifted offset from the sign-extend/shift stage.
- branch_pc  in  PC_WIDTH  base PC for target computation (PC+2 of the branch instruction).
- halt  in  1  halt instruction decoded.
- pc  out  PC_WIDTH  current fetch PC (registered).
- pc_plus  out  PC_WIDTH  pc + INSTR_BYTES (combinational).
- flush  out  1  squash IF/ID contents (registered).
- redirect  out  1  one-cycle pulse: pc was loaded with a target this cycle (registered).
- halted  out  1  core halted (registered).
- misalign_err  out  1  sticky; only meaningful with PC_ALIGN_CHECK_EN, otherwise tied 0.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low on rst_n.
- Reset values, applied immediately when rst_n=0: pc=RESET_PC, flush=0, redirect=0, halted=0, misalign_err=0, state=RUN, flush counter=0.
- Target: target = (branch_pc + offset) mod 2^PC_WIDTH, with no overflow flag. Bit 0 of target is forced to 0 unless the optional feature is enabled.
- State RUN, evaluated in priority order each edge:
  1. stall=1: pc holds; branch_taken, jump and halt are ignored this cycle (the decoder keeps them asserted until stall drops).
  2. halt=1: pc holds; go to HALTED; halted=1 from the next cycle.
  3. branch_taken or jump: pc<=target, redirect=1 for that cycle, flush=1, counter<=FLUSH_CYCLES-1; go to FLUSH. If both branch_taken and jump are high, the result is the same single redirect.
  4. Otherwise: pc<=pc+INSTR_BYTES, wrapping from 16'hFFFE to 16'h0000.
- State FLUSH:
  - flush=1 throughout.
  - branch_taken, jump and halt are ignored, because they come from squashed instructions.
  - pc advances by INSTR_BYTES on unstalled cycles and holds on stalled cycles.
  - The counter decrements only on unstalled cycles.
  - When the counter is 0 on an unstalled cycle, go to RUN; flush=0 from the next cycle.
  - With FLUSH_CYCLES=1, flush is high for exactly one unstalled cycle.
- State HALTED: pc is frozen and halted=1. All inputs are ignored; only reset exits this state.
- Latency: a redirect is visible on pc one cycle after branch_taken/jump is sampled. The first fetch of the target occurs in that cycle.
- Reset mid-FLUSH or in HALTED: state returns to RUN immediately and flush drops asynchronously.
- redirect is never high in two consecutive cycles.

Optional Feature:
- Macro: PC_ALIGN_CHECK_EN.
- Defined: target bit 0 is not masked. If a redirect computes target[0]=1:
  - pc holds its old value;
  - no flush is issued;
  - misalign_err sets and stays high (sticky until reset);
  - state goes to HALTED, with halted=1 next cycle.
- Undefined: target[0] is forced to 0, misalign_err is tied to 0, and no alignment check logic is present.

Test Plan:
- Reset release, no stall, 4 cycles -> pc sequence 0000,0002,0004,0006,0008; flush=0, redirect=0.
- pc=0010, branch_pc=0012, offset=FFF8 (-8), branch_taken=1 -> next pc=000A, redirect pulse, flush=1 for one cycle, then pc=000C with flush=0.
- jump=1 with branch_pc=FFFE, offset=0004 -> pc wraps to 0002. Repeat at pc=FFFE with no redirect -> pc=0000.
- branch_taken=1 with stall=1 for 3 cycles, then stall=0 -> pc holds for 3 cycles and redirects only on the first unstalled edge. FLUSH_CYCLES=2 with a stall during flush -> flush stays high across the stall and the counter resumes afterwards.
- halt=1 at pc=0020 -> halted=1, pc stays 0020 for 10 cycles despite jump=1. rst_n pulse -> pc=0000, halted=0.
- PC_ALIGN_CHECK_EN defined, branch_pc=0011, offset=0000, jump=1 -> misalign_err=1, halted=1, pc unchanged. With the macro undefined, the same stimulus gives pc=0010.
